// File: rtl/debounce_edge.sv
// ============================================================================
// Module   : debounce_edge
// Purpose  : Debounces a synchronized level and emits one-cycle edge pulses.
//            Edge pulses are generated only when DEBOUNCE_EDGE_PULSE_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module debounce_edge #(
   parameter int unsigned STABLE_CYCLES = 16
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic stream_i,
   output logic level_o,
   output logic rise_o,
   output logic fall_o,
   output logic busy_o
);

   localparam int unsigned CNT_W = $clog2(STABLE_CYCLES);
   localparam logic [CNT_W-1:0] c_LAST = CNT_W'(STABLE_CYCLES - 1);

   if ((STABLE_CYCLES < 2) || (STABLE_CYCLES > 65535)) begin : g_bad_param
      $error("debounce_edge: STABLE_CYCLES must be in 2..65535");
   end

   typedef enum logic [1:0] {
      STABLE_LO = 2'd0,
      CHECK_HI  = 2'd1,
      STABLE_HI = 2'd2,
      CHECK_LO  = 2'd3
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic             r_level;
   logic             r_busy;
   logic             w_level_nxt;
   logic             w_busy_nxt;

   // Counter is cleared on every transition out of a CHECK state, so it never wraps.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = '0;
      case (r_state)
         STABLE_LO: begin
            if (stream_i) begin
               w_state_nxt = CHECK_HI;
               w_cnt_nxt   = CNT_W'(1);
            end
         end
         CHECK_HI: begin
            if (!stream_i) begin
               w_state_nxt = STABLE_LO;
            end else if (r_cnt == c_LAST) begin
               w_state_nxt = STABLE_HI;
            end else begin
               w_cnt_nxt   = r_cnt + CNT_W'(1);
            end
         end
         STABLE_HI: begin
            if (!stream_i) begin
               w_state_nxt = CHECK_LO;
               w_cnt_nxt   = CNT_W'(1);
            end
         end
         CHECK_LO: begin
            if (stream_i) begin
               w_state_nxt = STABLE_HI;
            end else if (r_cnt == c_LAST) begin
               w_state_nxt = STABLE_LO;
            end else begin
               w_cnt_nxt   = r_cnt + CNT_W'(1);
            end
         end
         default: begin
            w_state_nxt = STABLE_LO;
         end
      endcase
      w_level_nxt = (w_state_nxt == STABLE_HI) || (w_state_nxt == CHECK_LO);
      w_busy_nxt  = (w_state_nxt == CHECK_HI)  || (w_state_nxt == CHECK_LO);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state <= STABLE_LO;
         r_cnt   <= '0;
         r_level <= 1'b0;
         r_busy  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_level <= w_level_nxt;
         r_busy  <= w_busy_nxt;
      end
   end

   assign level_o = r_level;
   assign busy_o  = r_busy;

`ifdef DEBOUNCE_EDGE_PULSE_EN
   logic r_rise;
   logic r_fall;

   // Reset clears the level without a pulse, so a discarded high level never emits fall_o.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_rise <= 1'b0;
         r_fall <= 1'b0;
      end else begin
         r_rise <= w_level_nxt & ~r_level;
         r_fall <= ~w_level_nxt & r_level;
      end
   end

   assign rise_o = r_rise;
   assign fall_o = r_fall;
`else
   assign rise_o = 1'b0;
   assign fall_o = 1'b0;
`endif

endmodule

`default_nettype wire

// File: doc/debounce_edge.md
DEBOUNCE_EDGE -- requirements
Module: debounce_edge

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 16: number of consecutive equal samples needed to accept a new level; legal range 2..65535, any other value fails elaboration.
REQ-002 SHALL derive local parameter CNT_W = $clog2(STABLE_CYCLES): sample counter width.
REQ-003 SHALL have port clk_i  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst_i  input  1  synchronous, active-high reset.
REQ-005 SHALL have port stream_i  input  1  level already synchronized into clk_i by the upstream synchronizer stage; treated as glitch-prone but metastability-free.
REQ-006 SHALL have port level_o  output  1  debounced, registered level.
REQ-007 SHALL have port rise_o  output  1  one-cycle pulse when level_o goes 0->1.
REQ-008 SHALL have port fall_o  output  1  one-cycle pulse when level_o goes 1->0.
REQ-009 SHALL have port busy_o  output  1  high while a candidate level change is being qualified.

Function
REQ-010 SHALL implement FSM states STABLE_LO, CHECK_HI, STABLE_HI, CHECK_LO; level_o = 1 exactly in STABLE_HI and CHECK_LO.
REQ-011 STABLE_LO: stream_i=1 -> CHECK_HI, counter <= 1; else stay, counter <= 0.
REQ-012 CHECK_HI: stream_i=0 -> STABLE_LO, counter <= 0; stream_i=1 and counter = STABLE_CYCLES-1 -> STABLE_HI, counter <= 0; otherwise counter <= counter+1.
REQ-013 STABLE_HI and CHECK_LO SHALL mirror REQ-011/REQ-012 with stream_i polarity inverted.
REQ-014 Latency: if stream_i changes before edge k and holds, level_o SHALL change at edge k+STABLE_CYCLES-1 (visible after it), i.e. after exactly STABLE_CYCLES high (or low) samples.
REQ-015 Any opposing sample during CHECK_* SHALL abort qualification and restart from count 0; no partial credit is retained.
REQ-016 Counter SHALL never exceed STABLE_CYCLES-1 and SHALL never wrap.
REQ-017 busy_o SHALL be registered and equal 1 exactly in CHECK_HI and CHECK_LO.
REQ-018 rise_o/fall_o SHALL be registered, asserted for exactly one cycle, coincident with the first cycle of the new level_o value; never both high together.
REQ-019 A pulse stream shorter than STABLE_CYCLES samples SHALL produce no level_o change and no edge pulse.

Reset
REQ-020 While rst_i=1 at a clock edge: state <= STABLE_LO, counter <= 0, level_o <= 0, rise_o <= 0, fall_o <= 0, busy_o <= 0.
REQ-021 Reset asserted mid-qualification or in STABLE_HI SHALL discard state without emitting fall_o.
REQ-022 First edge after rst_i deasserts SHALL evaluate stream_i per REQ-011; a stream_i held high through reset SHALL raise level_o STABLE_CYCLES-1 edges after the first post-reset edge, with rise_o.

Configuration
REQ-023 Macro DEBOUNCE_EDGE_PULSE_EN SHALL control edge-pulse generation.
REQ-024 With DEBOUNCE_EDGE_PULSE_EN defined: rise_o/fall_o behave per REQ-018.
REQ-025 Without it: rise_o and fall_o ports remain present and SHALL be constant 0; no pulse registers are synthesized; level_o and busy_o are unaffected.

Verification (STABLE_CYCLES=4, macro defined unless stated)
REQ-026 Reset, stream_i=0 for 10 cycles -> level_o=0, busy_o=0, no pulses.
REQ-027 stream_i 0->1 before edge 5, held -> busy_o=1 after edges 5-7, level_o=1 and rise_o=1 after edge 8, rise_o=0 after edge 9.
REQ-028 stream_i high 3 samples then low (glitch) -> busy_o returns 0, level_o stays 0, no rise_o.
REQ-029 From level_o=1, stream_i low 2 samples, high 1, low 4 -> level_o falls only after 4th consecutive low sample, single fall_o pulse.
REQ-030 rst_i asserted during CHECK_HI at count 2 -> next cycle level_o=0, busy_o=0, counter 0; qualification restarts from zero after release.
REQ-031 Macro undefined, repeat REQ-027 -> identical level_o timing, rise_o and fall_o constant 0.
